// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU execute stage.
//   alu_op_e     - 3-bit ALU operation codes (shared with the opcode decoder)
//   shift_e      - operand-2 shift types
//   exec_state_e - execute-stage FSM states
//   FLAG_*       - bit positions of N, Z, C, V inside a 4-bit NZCV vector
package alu_pkg;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned SHAMT_W = 5;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_ORR   = 3'b011,
    OP_XOR   = 3'b100,
    OP_NOT   = 3'b101,
    OP_PASSA = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_EXEC  = 2'b10,
    ST_DONE  = 2'b11
  } exec_state_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU with NZCV flag generation.
// Ports:
//   op_i     - ALU operation
//   a_i      - operand A
//   b_i      - shifted operand B'
//   shc_i    - shifter carry (C for logical / move ops)
//   v_i      - incoming V flag (preserved for non-arithmetic ops)
//   result_o - ALU result
//   flags_o  - NZCV flags for result_o
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  alu_op_e              op_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 shc_i,
  input  logic                 v_i,
  output logic [WIDTH-1:0]     result_o,
  output logic [FLAGS_W-1:0]   flags_o
);

  logic [WIDTH:0] sum;
  logic           c_out;
  logic           v_out;

  // Result select plus carry/overflow; SUB is A + ~B' + 1 so C is NOT borrow.
  always_comb begin
    sum      = '0;
    c_out    = shc_i;
    v_out    = v_i;
    result_o = '0;
    case (op_i)
      OP_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[WIDTH-1:0];
        c_out    = sum[WIDTH];
        v_out    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        sum      = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
        result_o = sum[WIDTH-1:0];
        c_out    = sum[WIDTH];
        v_out    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:   result_o = a_i & b_i;
      OP_ORR:   result_o = a_i | b_i;
      OP_XOR:   result_o = a_i ^ b_i;
      OP_NOT:   result_o = ~b_i;
      OP_PASSA: result_o = a_i;
      default:  result_o = b_i;
    endcase
    flags_o         = '0;
    flags_o[FLAG_N] = result_o[WIDTH-1];
    flags_o[FLAG_Z] = (result_o == '0);
    flags_o[FLAG_C] = c_out;
    flags_o[FLAG_V] = v_out;
  end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle execute stage (shift operand 2, then ALU + NZCV).
// Optional build macro: ALU_FAST_SHIFT_EN selects a single-cycle barrel
// shifter in EXEC instead of one-bit-per-cycle iteration in SHIFT.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   i_valid / o_ready       - request handshake
//   i_alu_op, i_a, i_b      - operation and operands
//   i_shift_type/amt        - operand-2 shift description (amount 0 = no shift)
//   i_flags                 - current NZCV from CPSR
//   o_valid / i_ready       - result handshake
//   o_result, o_flags       - registered result and NZCV
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_alu_op,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [1:0]           i_shift_type,
  input  logic [SHAMT_W-1:0]   i_shift_amt,
  input  logic [FLAGS_W-1:0]   i_flags,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_result,
  output logic [FLAGS_W-1:0]   o_flags
);

  exec_state_e          state_q, state_d;
  alu_op_e              op_q, op_d;
  shift_e               sht_q, sht_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 c_q, c_d;
  logic                 v_q, v_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [FLAGS_W-1:0]   flags_q, flags_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;

  logic [WIDTH-1:0]     b_sh;
  logic                 c_sh;
  logic [WIDTH-1:0]     core_res;
  logic [FLAGS_W-1:0]   core_flags;

  // N and Z of the incoming CPSR are never consumed here.
  logic unused_flags;
  assign unused_flags = ^i_flags[FLAG_N:FLAG_Z];

`ifdef ALU_FAST_SHIFT_EN
  logic [WIDTH:0]   lsl_w, lsr_w, asr_w;
  logic [WIDTH-1:0] ror_w;

  // Barrel shift of the captured B by the captured amount; the extra bit
  // beside the data catches the last bit shifted out.
  always_comb begin
    lsl_w = {1'b0, b_q} << cnt_q;
    lsr_w = {b_q, 1'b0} >> cnt_q;
    asr_w = $signed({b_q, 1'b0}) >>> cnt_q;
    ror_w = (b_q >> cnt_q) | (b_q << (WIDTH - 32'(cnt_q)));
    b_sh  = b_q;
    c_sh  = c_q;
    if (cnt_q != '0) begin
      case (sht_q)
        SH_LSL:  begin b_sh = lsl_w[WIDTH-1:0]; c_sh = lsl_w[WIDTH];    end
        SH_LSR:  begin b_sh = lsr_w[WIDTH:1];   c_sh = lsr_w[0];        end
        SH_ASR:  begin b_sh = asr_w[WIDTH:1];   c_sh = asr_w[0];        end
        default: begin b_sh = ror_w;            c_sh = ror_w[WIDTH-1];  end
      endcase
    end
  end
`else
  assign b_sh = b_q;
  assign c_sh = c_q;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_sh),
    .shc_i    (c_sh),
    .v_i      (v_q),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sht_d    = sht_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    v_d      = v_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          op_d  = alu_op_e'(i_alu_op);
          sht_d = shift_e'(i_shift_type);
          a_d   = i_a;
          b_d   = i_b;
          cnt_d = i_shift_amt;
          c_d   = i_flags[FLAG_C];
          v_d   = i_flags[FLAG_V];
`ifdef ALU_FAST_SHIFT_EN
          state_d = ST_EXEC;
`else
          state_d = (i_shift_amt != '0) ? ST_SHIFT : ST_EXEC;
`endif
        end
      end
      ST_SHIFT: begin
        // One bit per cycle; carry holds the most recently shifted-out bit.
        case (sht_q)
          SH_LSL: begin c_d = b_q[WIDTH-1]; b_d = {b_q[WIDTH-2:0], 1'b0};        end
          SH_LSR: begin c_d = b_q[0];       b_d = {1'b0, b_q[WIDTH-1:1]};        end
          SH_ASR: begin c_d = b_q[0];       b_d = {b_q[WIDTH-1], b_q[WIDTH-1:1]}; end
          default: begin c_d = b_q[0];      b_d = {b_q[0], b_q[WIDTH-1:1]};      end
        endcase
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = core_res;
        flags_d  = core_flags;
        state_d  = ST_DONE;
      end
      default: begin
        if (i_ready) state_d = ST_IDLE;
      end
    endcase
    valid_d = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      sht_q    <= SH_LSL;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sht_q    <= sht_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      v_q      <= v_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;

endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle execute stage of the ARMv7 datapath. It sits directly downstream of the ALU opcode decoder. It consumes the 3-bit ALU opcode, the operands and the operand-2 shift description. It produces the result and the NZCV flags; the decoder's CPSR register latches those flags. A valid/ready handshake on both sides lets shifts be iterated one bit per cycle.

## Interface
- WIDTH, 32, datapath width; shift amount stays 5 bits.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  request valid.
- o_ready  out  1  stage can accept a request.
- i_alu_op  in  3  000 ADD, 001 SUB (A−B), 010 AND, 011 ORR, 100 XOR, 101 NOT (~B'), 110 PASS A, 111 PASS B'.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B before shifting; B' is the shifted value.
- i_shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- i_shift_amt  in  5  0–31; 0 means no shift (no RRX).
- i_flags  in  4  current NZCV {N,Z,C,V} from CPSR.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_result  out  WIDTH  registered result.
- o_flags  out  4  registered NZCV for the result.

## Operation
- States: IDLE, SHIFT, EXEC, DONE. o_ready = (state == IDLE).
- IDLE: on i_valid & o_ready, capture all inputs and load count = i_shift_amt.
  - Go to SHIFT if count != 0, else EXEC.
- SHIFT: each cycle shifts B' by one bit per type and records the bit shifted out as shifter carry; count decrements.
  - When count == 1 the final step is taken and the state goes to EXEC.
- Shift bit rules:
  - LSL fills 0.
  - LSR fills 0.
  - ASR fills B'[WIDTH−1].
  - ROR rotates bit 0 into the MSB.
- Shifter carry = last bit shifted out. With amount 0, shifter carry = i_flags.C.
- EXEC: compute and register o_result and o_flags, then go to DONE.
- DONE: o_valid = 1. Result and flags are held stable until i_ready, then the state goes to IDLE.
- Flags:
  - N = result[WIDTH−1].
  - Z = (result == 0).
  - ADD: C = carry out of the (WIDTH+1)-bit sum; V = signed overflow.
  - SUB: computed as A + ~B' + 1; C = NOT borrow; V = signed overflow.
  - Logical, NOT and PASS ops: C = shifter carry, V = captured i_flags.V.
- All arithmetic is modulo 2^WIDTH. Captured inputs are immune to input changes after the accept cycle.
- i_valid while not in IDLE is ignored; the upstream stage must hold its request.

## Timing
- Reset: state IDLE, o_valid 0, o_result 0, o_flags 0, count 0. o_ready is 1 from the first cycle after reset.
- Request accepted in cycle k with amount N:
  - SHIFT occupies cycles k+1..k+N.
  - EXEC occupies cycle k+N+1.
  - o_valid is high from cycle k+N+2.
- Throughput: DONE handshake in cycle d → IDLE in d+1 → next accept no earlier than d+1.
- Reset mid-SHIFT, mid-EXEC or mid-DONE: the transaction is abandoned. All outputs return to their reset values on the next edge and no partial result is emitted.
- Reset has priority over a simultaneous accept or a simultaneous DONE handshake.

## Configuration
- ALU_FAST_SHIFT_EN defined: a combinational barrel shifter produces B' and shifter carry during EXEC.
  - SHIFT state is never entered.
  - Latency is always k+2 regardless of amount.
  - Flag and carry results are bit-identical to the iterative version.
- Not defined: iterative one-bit-per-cycle shifting as described under Operation; area-minimal.

## Structure
- Package alu_pkg holds:
  - alu_op_e (3-bit ALU codes, shared with the decoder);
  - shift_e;
  - exec_state_e;
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_core: purely combinational. Inputs are op, A, B', shifter carry and V_in; outputs are result and NZCV. It is instantiated once in EXEC.
- The FSM, counter and shifter remain in alu_exec.

## Test plan
- ADD A=0x7FFFFFFF, B=1, amt 0, flags 0 → result 0x80000000, NZCV=1001, o_valid in cycle k+2.
- SUB A=5, B=5 → result 0, NZCV=0110.
- ORR A=0, B=0x10000001, LSL 4, flags V=1 → result 0x00000010, NZCV=0011.
  - o_valid at k+6 without the macro, k+2 with it.
- PASS B, B=0x80000000, ASR 31 → result 0xFFFFFFFF, NZCV=1000. ROR 1 of 0x00000001 → 0x80000000, C=1.
- Hold i_ready=0 for 3 cycles in DONE while pulsing i_valid → o_result and o_flags stable, o_ready=0, no extra transaction accepted.
- Assert reset in cycle k+2 of an LSL 10 request → o_valid never asserts, outputs zero, o_ready=1 the cycle after reset drops.
